sysbus_arbiter: RTL and testbench
=================================

// Module: sysbus_arbiter
// PURPOSE
//  Shares the single Sysbus master port between the instruction-fetch requester (port I) and the
//  data/memory-stage requester (port D). Grants one requester at a time, forwards its address
//  phase, write data beats and response beats, and holds ownership until the transaction completes.
//  Sits between Core's fetch/MEM logic and the Sysbus; exactly one transaction is outstanding.
// PARAMETERS
//  BEATS   8   64-bit beats per transaction (64-byte line)
//  ADDR_W  64  request address/data width (req/resp)
//  TAG_W   13  reqtag/resptag width ({READ/WRITE, MEMORY, 8'b0} encoding)
// PORTS
//  clk          in   1       bus clock (Sysbus clk)
//  reset        in   1       asynchronous, active-high reset
//  i_reqcyc     in   1       fetch request valid; held with i_req/i_reqtag until i_reqack
//  i_req        in   ADDR_W  fetch line address
//  i_reqtag     in   TAG_W   fetch tag (always READ)
//  i_reqack     out  1       fetch address accepted (1-cycle pulse)
//  i_respcyc    out  1       fetch response beat valid
//  i_resp       out  ADDR_W  fetch response data
//  i_respack    in   1       fetch accepts beat
//  d_reqcyc/d_req/d_reqtag/d_reqack/d_respcyc/d_resp/d_respack  same as i_*, data requester (READ or WRITE)
//  bus_reqcyc   out  1       Sysbus request valid
//  bus_req      out  ADDR_W  Sysbus address / write data beat
//  bus_reqtag   out  TAG_W   Sysbus tag
//  bus_reqack   in   1       Sysbus accepts address or write beat
//  bus_respcyc  in   1       Sysbus response beat valid
//  bus_resp     in   ADDR_W  Sysbus response data
//  bus_resptag  in   TAG_W   Sysbus response tag (checked by assertion only)
//  bus_respack  out  1       response beat accepted
// BEHAVIOUR
//  Reset: state=IDLE, owner=I, beat_cnt=0, last_grant=D; bus_reqcyc/bus_req/bus_reqtag=0; all acks/respcyc=0.
//  States: IDLE -> ADDR -> (WDATA if WRITE) or RESP -> IDLE.
//  IDLE: sample i_reqcyc/d_reqcyc; if any set, pick owner (arbitration below), register owner's req/reqtag
//   into bus_req/bus_reqtag, set bus_reqcyc=1 next cycle, go ADDR. Grant-to-bus latency: 1 cycle.
//  ADDR: hold bus_reqcyc/req/reqtag stable; on bus_reqack: owner's reqack=1 same cycle (comb.), bus_reqcyc=0
//   next cycle, beat_cnt=0; go WDATA if reqtag is WRITE else RESP. Non-owner reqack never asserts.
//  WDATA: bus_reqcyc/bus_req combinationally = owner's reqcyc/req; owner's reqack = bus_reqack; each
//   reqcyc&reqack increments beat_cnt; at beat BEATS-1 go IDLE (no response phase for writes).
//  RESP: owner's respcyc/resp = bus_respcyc/bus_resp; bus_respack = owner's respack; non-owner respcyc=0.
//   Each bus_respcyc&bus_respack increments beat_cnt; on beat BEATS-1 go IDLE same cycle edge.
//  beat_cnt is $clog2(BEATS) wide and wraps to 0 on transaction end; never counts outside WDATA/RESP.
//  bus_respcyc outside RESP: ignored, bus_respack=0, assertion fires (protocol error).
//  Requester dropping reqcyc in ADDR: not allowed; assertion fires; transaction still completes.
//  Simultaneous completion and new request: new request is sampled in IDLE the cycle after (no back-to-back
//   bypass); min gap between transactions is 1 idle cycle.
//  Async reset mid-transaction: immediately IDLE, all outputs 0; in-flight beats after reset are dropped.
// CONFIGURATION
//  SYSBUS_ARB_RR_EN defined: round-robin; when both request in IDLE, grant the one not in last_grant;
//   last_grant updated on every grant.
//  SYSBUS_ARB_RR_EN undefined: fixed priority, D always wins over I; last_grant kept but unused.
// TESTING
//  I read 0x1000 alone, bus acks after 3 cycles, 8 beats -> bus_reqcyc at +1, i_reqack once, i_respcyc x8, IDLE.
//  I and D both request in same IDLE cycle (no RR) -> D granted first, I granted after D's 8th beat + 1 cycle.
//  RR on, I and D continuously requesting -> grants alternate D,I,D,I; no starvation over 10 transactions.
//  D write 0x2000, 8 data beats with bus_reqack stalls on beats 2 and 5 -> exactly 8 beats forwarded, no resp phase.
//  Response with i_respack low 2 cycles mid-burst -> bus_respack low, beat_cnt held, 8 beats total delivered.
//  Assert reset during RESP beat 4 -> all outputs 0 same cycle, IDLE; next I request served normally.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// Two-requester (fetch I / data D) arbiter onto a single Sysbus master port, one transaction in flight.
// Optional `SYSBUS_ARB_RR_EN selects round-robin arbitration; default build is fixed priority (D over I).
module sysbus_arbiter #(
    parameter int BEATS  = 8,
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_reqcyc,
    input  logic [ADDR_W-1:0] i_req,
    input  logic [TAG_W-1:0]  i_reqtag,
    output logic              i_reqack,
    output logic              i_respcyc,
    output logic [ADDR_W-1:0] i_resp,
    input  logic              i_respack,
    input  logic              d_reqcyc,
    input  logic [ADDR_W-1:0] d_req,
    input  logic [TAG_W-1:0]  d_reqtag,
    output logic              d_reqack,
    output logic              d_respcyc,
    output logic [ADDR_W-1:0] d_resp,
    input  logic              d_respack,
    output logic              bus_reqcyc,
    output logic [ADDR_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [ADDR_W-1:0] bus_resp,
    input  logic [TAG_W-1:0]  bus_resptag,
    output logic              bus_respack
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;          // 0 = I, 1 = D
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              bus_reqcyc_q, bus_reqcyc_d;
    logic [ADDR_W-1:0] bus_req_q, bus_req_d;
    logic [TAG_W-1:0]  bus_reqtag_q, bus_reqtag_d;

    logic              own_reqcyc, own_respack, pick_d, wr_beat, rd_beat;
    logic [ADDR_W-1:0] own_req;

    assign own_reqcyc  = owner_q ? d_reqcyc  : i_reqcyc;
    assign own_req     = owner_q ? d_req     : i_req;
    assign own_respack = owner_q ? d_respack : i_respack;
    assign wr_beat     = own_reqcyc && bus_reqack;
    assign rd_beat     = bus_respcyc && own_respack;

    always_comb begin
`ifdef SYSBUS_ARB_RR_EN
        pick_d = (i_reqcyc && d_reqcyc) ? ~last_grant_q : d_reqcyc;
`else
        pick_d = d_reqcyc;
`endif
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        bus_reqcyc_d = bus_reqcyc_q;
        bus_req_d    = bus_req_q;
        bus_reqtag_d = bus_reqtag_q;
        unique case (state_q)
            IDLE: if (i_reqcyc || d_reqcyc) begin
                owner_d      = pick_d;
                last_grant_d = pick_d;
                bus_req_d    = pick_d ? d_req    : i_req;
                bus_reqtag_d = pick_d ? d_reqtag : i_reqtag;
                bus_reqcyc_d = 1'b1;
                state_d      = ADDR;
            end
            ADDR: if (bus_reqack) begin
                bus_reqcyc_d = 1'b0;
                beat_cnt_d   = '0;
                // Tag MSB is the READ flag: 0 means WRITE, which has a data phase and no response
                state_d      = bus_reqtag_q[TAG_W-1] ? RESP : WDATA;
            end
            WDATA: if (wr_beat) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (beat_cnt_q == LAST_BEAT) begin
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            RESP: if (rd_beat) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (beat_cnt_q == LAST_BEAT) begin
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            bus_reqcyc_q <= 1'b0;
            bus_req_q    <= '0;
            bus_reqtag_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            bus_reqcyc_q <= bus_reqcyc_d;
            bus_req_q    <= bus_req_d;
            bus_reqtag_q <= bus_reqtag_d;
        end
    end

    // Write beats pass straight through so the requester sees the bus handshake with no extra latency
    always_comb begin
        bus_reqcyc  = bus_reqcyc_q;
        bus_req     = bus_req_q;
        bus_reqtag  = bus_reqtag_q;
        bus_respack = 1'b0;
        i_reqack    = 1'b0;
        d_reqack    = 1'b0;
        i_respcyc   = 1'b0;
        d_respcyc   = 1'b0;
        i_resp      = '0;
        d_resp      = '0;
        if (state_q == ADDR || state_q == WDATA) begin
            i_reqack = !owner_q && bus_reqack;
            d_reqack = owner_q && bus_reqack;
        end
        if (state_q == WDATA) begin
            bus_reqcyc = own_reqcyc;
            bus_req    = own_req;
        end
        if (state_q == RESP) begin
            bus_respack = own_respack;
            i_respcyc   = !owner_q && bus_respcyc;
            d_respcyc   = owner_q && bus_respcyc;
            i_resp      = owner_q ? '0 : bus_resp;
            d_resp      = owner_q ? bus_resp : '0;
        end
    end

`ifndef SYNTHESIS
    a_resp_outside: assert property (@(posedge clk) disable iff (reset)
        (state_q != RESP) |-> !bus_respcyc);
    a_req_drop: assert property (@(posedge clk) disable iff (reset)
        (state_q == ADDR) |-> own_reqcyc);
    a_resptag: assert property (@(posedge clk) disable iff (reset)
        (state_q == RESP && bus_respcyc) |-> (bus_resptag == bus_reqtag_q));
`endif
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: reads, write burst, stalls, arbitration order and mid-burst reset.
module tb_sysbus_arbiter;
    localparam int BEATS = 8;
    localparam int AW    = 64;
    localparam int TW    = 13;
    localparam logic [TW-1:0] TAG_RD = {1'b1, 4'b0001, 8'h00};
    localparam logic [TW-1:0] TAG_WR = {1'b0, 4'b0001, 8'h00};

    logic          clk = 1'b0;
    logic          reset;
    logic          i_reqcyc, i_reqack, i_respcyc, i_respack;
    logic [AW-1:0] i_req, i_resp;
    logic [TW-1:0] i_reqtag;
    logic          d_reqcyc, d_reqack, d_respcyc, d_respack;
    logic [AW-1:0] d_req, d_resp;
    logic [TW-1:0] d_reqtag;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [AW-1:0] bus_req, bus_resp;
    logic [TW-1:0] bus_reqtag, bus_resptag;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sysbus_arbiter #(.BEATS(BEATS), .ADDR_W(AW), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_reqack(i_reqack),
        .i_respcyc(i_respcyc), .i_resp(i_resp), .i_respack(i_respack),
        .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqack(d_reqack),
        .d_respcyc(d_respcyc), .d_resp(d_resp), .d_respack(d_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with requests already presented; bus acks the address after ack_dly cycles.
    task automatic addr_phase(input bit own_d, input logic [63:0] addr, input logic [TW-1:0] tag,
                              input int ack_dly);
        #1 chk("idle_busreqcyc", 64'(bus_reqcyc), 64'd0);
        cyc();
        for (int k = 0; k <= ack_dly; k++) begin
            bus_reqack = (k == ack_dly);
            #1;
            chk("addr_busreqcyc", 64'(bus_reqcyc), 64'd1);
            chk("addr_busreq", bus_req, addr);
            chk("addr_bustag", 64'(bus_reqtag), 64'(tag));
            chk("addr_own_ack", 64'(own_d ? d_reqack : i_reqack), 64'(k == ack_dly));
            chk("addr_oth_ack", 64'(own_d ? i_reqack : d_reqack), 64'd0);
            cyc();
        end
        bus_reqack = 1'b0;
    endtask

    // Response burst; owner holds respack low for 2 cycles at beat stall_at; reset asserted at beat abort_at.
    task automatic resp_phase(input bit own_d, input logic [63:0] base, input int stall_at,
                              input int abort_at);
        int beats = 0;
        int guard = 0;
        int stall = 0;
        bit armed = (stall_at >= 0);
        bit ack;
        while (beats < BEATS && guard < 4 * BEATS) begin
            guard++;
            if (armed && beats == stall_at) begin
                stall = 2;
                armed = 1'b0;
            end
            ack = (stall == 0);
            if (stall > 0) stall--;
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(beats);
            bus_resptag = TAG_RD;
            i_respack   = own_d ? 1'b1 : ack;
            d_respack   = own_d ? ack : 1'b1;
            if (beats == abort_at) begin
                reset = 1'b1;
                #1;
                chk("rst_respcyc", 64'({i_respcyc, d_respcyc}), 64'd0);
                chk("rst_resp", i_resp | d_resp, 64'd0);
                chk("rst_busrespack", 64'(bus_respack), 64'd0);
                chk("rst_busreqcyc", 64'(bus_reqcyc), 64'd0);
                chk("rst_busreq", bus_req, 64'd0);
                chk("rst_bustag", 64'(bus_reqtag), 64'd0);
                chk("rst_reqack", 64'({i_reqack, d_reqack}), 64'd0);
                bus_respcyc = 1'b0;
                i_respack   = 1'b0;
                d_respack   = 1'b0;
                cyc();
                reset = 1'b0;
                return;
            end
            #1;
            chk("resp_own_cyc", 64'(own_d ? d_respcyc : i_respcyc), 64'd1);
            chk("resp_own_data", own_d ? d_resp : i_resp, base + 64'(beats));
            chk("resp_oth_cyc", 64'(own_d ? i_respcyc : d_respcyc), 64'd0);
            chk("resp_busack", 64'(bus_respack), 64'(ack));
            if (ack) beats++;
            cyc();
        end
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        i_respack   = 1'b1;
        d_respack   = 1'b1;
        #1;
        chk("resp_done_busack", 64'(bus_respack), 64'd0);
        chk("resp_beats", 64'(beats), 64'(BEATS));
        i_respack = 1'b0;
        d_respack = 1'b0;
    endtask

    // D write data beats; bus stalls one cycle on first visit to beats 2 and 5.
    task automatic wdata_phase(input logic [63:0] base);
        int beats = 0;
        int guard = 0;
        bit stalled[BEATS];
        for (int k = 0; k < BEATS; k++) stalled[k] = 1'b0;
        while (beats < BEATS && guard < 4 * BEATS) begin
            guard++;
            d_reqcyc   = 1'b1;
            d_req      = base + 64'(beats);
            bus_reqack = !((beats == 2 || beats == 5) && !stalled[beats]);
            stalled[beats] = 1'b1;
            #1;
            chk("wr_busreqcyc", 64'(bus_reqcyc), 64'd1);
            chk("wr_busreq", bus_req, base + 64'(beats));
            chk("wr_d_ack", 64'(d_reqack), 64'(bus_reqack));
            chk("wr_i_ack", 64'(i_reqack), 64'd0);
            if (bus_reqack) beats++;
            cyc();
        end
        d_reqcyc   = 1'b0;
        bus_reqack = 1'b1;
        d_respack  = 1'b1;
        #1;
        chk("wr_done_ack", 64'(d_reqack), 64'd0);
        chk("wr_no_resp", 64'(bus_respack), 64'd0);
        chk("wr_beats", 64'(beats), 64'(BEATS));
        bus_reqack = 1'b0;
        d_respack  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_reqcyc = 0; i_req = '0; i_reqtag = '0; i_respack = 0;
        d_reqcyc = 1; d_req = 64'h2fff; d_reqtag = TAG_RD; d_respack = 1;
        bus_reqack = 1; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busreqcyc", 64'(bus_reqcyc), 64'd0);
        chk("reset_busreq", bus_req, 64'd0);
        chk("reset_bustag", 64'(bus_reqtag), 64'd0);
        chk("reset_acks", 64'({i_reqack, d_reqack, bus_respack}), 64'd0);
        chk("reset_respcyc", 64'({i_respcyc, d_respcyc}), 64'd0);
        d_reqcyc = 0; d_respack = 0; bus_reqack = 0;
        reset = 1'b0;
        cyc();

        // I read alone, address acked after 3 wait cycles
        i_reqcyc = 1; i_req = 64'h1000; i_reqtag = TAG_RD;
        addr_phase(1'b0, 64'h1000, TAG_RD, 3);
        i_reqcyc = 0;
        resp_phase(1'b0, 64'hA000, -1, -1);

        // I and D together: D first, I one idle cycle after D's last beat
        i_reqcyc = 1; i_req = 64'h1100; i_reqtag = TAG_RD;
        d_reqcyc = 1; d_req = 64'h2100; d_reqtag = TAG_RD;
        addr_phase(1'b1, 64'h2100, TAG_RD, 0);
        d_reqcyc = 0;
        resp_phase(1'b1, 64'hB000, -1, -1);
        addr_phase(1'b0, 64'h1100, TAG_RD, 1);
        i_reqcyc = 0;
        resp_phase(1'b0, 64'hB100, -1, -1);

        // D write with data-beat stalls
        d_reqcyc = 1; d_req = 64'h2000; d_reqtag = TAG_WR;
        addr_phase(1'b1, 64'h2000, TAG_WR, 1);
        wdata_phase(64'hD000);

        // I read with requester back-pressure mid-burst
        i_reqcyc = 1; i_req = 64'h1200; i_reqtag = TAG_RD;
        addr_phase(1'b0, 64'h1200, TAG_RD, 0);
        i_reqcyc = 0;
        resp_phase(1'b0, 64'hE000, 3, -1);

        // Both requesting continuously for 10 transactions
        i_reqcyc = 1; i_req = 64'h1300; i_reqtag = TAG_RD;
        d_reqcyc = 1; d_req = 64'h2300; d_reqtag = TAG_RD;
        for (int t = 0; t < 10; t++) begin
            bit own_d;
`ifdef SYSBUS_ARB_RR_EN
            own_d = (t % 2 == 0);
`else
            own_d = 1'b1;
`endif
            addr_phase(own_d, own_d ? 64'h2300 : 64'h1300, TAG_RD, 0);
            resp_phase(own_d, 64'hC000 + 64'(t * 16), -1, -1);
        end
        i_reqcyc = 0;
        d_reqcyc = 0;

        // Reset during response beat 4, then a fresh I read
        i_reqcyc = 1; i_req = 64'h1400; i_reqtag = TAG_RD;
        addr_phase(1'b0, 64'h1400, TAG_RD, 0);
        i_reqcyc = 0;
        resp_phase(1'b0, 64'hF000, -1, 4);
        i_reqcyc = 1; i_req = 64'h1500; i_reqtag = TAG_RD;
        addr_phase(1'b0, 64'h1500, TAG_RD, 2);
        i_reqcyc = 0;
        resp_phase(1'b0, 64'hF100, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
